// File: rtl/pid_filter_pkg.sv
// Shared endpoint map, config-select encoding and saturation helper for pid_filter.
package pid_filter_pkg;

    localparam int unsigned pid_setpoint_addr = 32'h0400;
    localparam int unsigned pid_p_coef_addr   = 32'h0401;
    localparam int unsigned pid_i_coef_addr   = 32'h0402;
    localparam int unsigned pid_d_coef_addr   = 32'h0403;
    localparam int unsigned pid_clr_rqst_addr = 32'h0404;

    typedef enum logic [2:0] {
        CfgNone,
        CfgSetpoint,
        CfgP,
        CfgI,
        CfgD,
        CfgClr
    } cfg_sel_e;

    // Clamp a sign-extended value into the signed range of 'width' bits.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] val,
                                                      input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (val > hi) return hi;
        if (val < lo) return lo;
        return val;
    endfunction

endpackage

// File: rtl/pid_filter_cfg_regs.sv
// Per-channel setpoint/gain registers, derived velocity-form gains and one-cycle clear requests.
module pid_filter_cfg_regs
    import pid_filter_pkg::*;
#(
    parameter int unsigned N_CHAN    = 8,
    parameter int unsigned W_IDX     = 3,
    parameter int unsigned W_DATA    = 18,
    parameter int unsigned W_COEF    = 16,
    parameter int unsigned W_WR_ADDR = 16,
    parameter int unsigned W_WR_CHAN = 16,
    parameter int unsigned W_WR_DATA = 48
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     wr_en,
    input  logic [W_WR_ADDR-1:0]     wr_addr,
    input  logic [W_WR_CHAN-1:0]     wr_chan,
    input  logic [W_WR_DATA-1:0]     wr_data,
    input  logic [W_IDX-1:0]         rd_idx,
    output logic signed [W_DATA-1:0] rd_setpoint,
    output logic signed [W_COEF+1:0] rd_k1,
    output logic signed [W_COEF+1:0] rd_k2,
    output logic signed [W_COEF+1:0] rd_k3,
    output logic [N_CHAN-1:0]        clr_rqst
);

    localparam int unsigned KW = W_COEF + 2;

    logic signed [W_DATA-1:0] setpoint_q [N_CHAN];
    logic signed [W_COEF-1:0] p_q [N_CHAN];
    logic signed [W_COEF-1:0] i_q [N_CHAN];
    logic signed [W_COEF-1:0] d_q [N_CHAN];
    logic signed [KW-1:0]     k1_q [N_CHAN];
    logic signed [KW-1:0]     k2_q [N_CHAN];
    logic signed [KW-1:0]     k3_q [N_CHAN];
    logic [N_CHAN-1:0]        clr_rqst_q;

    cfg_sel_e                 sel;
    logic [W_IDX-1:0]         wr_idx;
    logic signed [W_COEF-1:0] wr_coef;
    logic signed [W_COEF-1:0] p_nx, i_nx, d_nx;
    logic signed [KW-1:0]     p_x, i_x, d_x;
    logic signed [KW-1:0]     k1_nx, k2_nx, k3_nx;
    logic                     unused_wr_data;

    assign wr_idx         = wr_chan[W_IDX-1:0];
    assign wr_coef        = wr_data[W_COEF-1:0];
    assign unused_wr_data = ^wr_data[W_WR_DATA-1:W_DATA];

    always_comb begin
        sel = CfgNone;
        if (wr_en && (wr_chan < W_WR_CHAN'(N_CHAN))) begin
            if (wr_addr == W_WR_ADDR'(pid_setpoint_addr))      sel = CfgSetpoint;
            else if (wr_addr == W_WR_ADDR'(pid_p_coef_addr))   sel = CfgP;
            else if (wr_addr == W_WR_ADDR'(pid_i_coef_addr))   sel = CfgI;
            else if (wr_addr == W_WR_ADDR'(pid_d_coef_addr))   sel = CfgD;
            else if (wr_addr == W_WR_ADDR'(pid_clr_rqst_addr)) sel = CfgClr;
        end
    end

    // Derived gains are built from the post-write gain set so they land in the same edge.
    always_comb begin
        p_nx  = (sel == CfgP) ? wr_coef : p_q[wr_idx];
        i_nx  = (sel == CfgI) ? wr_coef : i_q[wr_idx];
        d_nx  = (sel == CfgD) ? wr_coef : d_q[wr_idx];
        p_x   = {{2{p_nx[W_COEF-1]}}, p_nx};
        i_x   = {{2{i_nx[W_COEF-1]}}, i_nx};
        d_x   = {{2{d_nx[W_COEF-1]}}, d_nx};
        k1_nx = p_x + i_x + d_x;
        k2_nx = -p_x - d_x - d_x;
        k3_nx = d_x;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int unsigned c = 0; c < N_CHAN; c++) begin
                setpoint_q[c] <= '0;
                p_q[c]        <= '0;
                i_q[c]        <= '0;
                d_q[c]        <= '0;
                k1_q[c]       <= '0;
                k2_q[c]       <= '0;
                k3_q[c]       <= '0;
            end
            clr_rqst_q <= '0;
        end else begin
            clr_rqst_q <= '0;
            unique case (sel)
                CfgSetpoint: setpoint_q[wr_idx] <= wr_data[W_DATA-1:0];
                CfgP, CfgI, CfgD: begin
                    p_q[wr_idx]  <= p_nx;
                    i_q[wr_idx]  <= i_nx;
                    d_q[wr_idx]  <= d_nx;
                    k1_q[wr_idx] <= k1_nx;
                    k2_q[wr_idx] <= k2_nx;
                    k3_q[wr_idx] <= k3_nx;
                end
                CfgClr:  clr_rqst_q[wr_idx] <= wr_data[0];
                default: ;
            endcase
        end
    end

    assign rd_setpoint = setpoint_q[rd_idx];
    assign rd_k1       = k1_q[rd_idx];
    assign rd_k2       = k2_q[rd_idx];
    assign rd_k3       = k3_q[rd_idx];
    assign clr_rqst    = clr_rqst_q;

endmodule

// File: rtl/pid_filter.sv
// Per-channel velocity-form PID: u = u1 + k1*e + k2*e1 + k3*e2, three-stage pipeline with
// same-channel hazards resolved by reading state as late as each stage needs it.
module pid_filter
    import pid_filter_pkg::*;
#(
    parameter int unsigned W_CHAN    = 5,
    parameter int unsigned N_CHAN    = 8,
    parameter int unsigned W_DATA    = 18,
    parameter int unsigned W_COEF    = 16,
    parameter int unsigned W_OUT     = 48,
    parameter int unsigned W_WR_ADDR = 16,
    parameter int unsigned W_WR_CHAN = 16,
    parameter int unsigned W_WR_DATA = 48
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 dv_in,
    input  logic [W_CHAN-1:0]    chan_in,
    input  logic [W_DATA-1:0]    data_in,
    input  logic                 wr_en,
    input  logic [W_WR_ADDR-1:0] wr_addr,
    input  logic [W_WR_CHAN-1:0] wr_chan,
    input  logic [W_WR_DATA-1:0] wr_data,
    output logic                 dv_out,
    output logic [W_CHAN-1:0]    chan_out,
    output logic [W_OUT-1:0]     data_out
);

    localparam int unsigned W_IDX = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
    localparam int unsigned EW    = W_DATA + 1;
    localparam int unsigned KW    = W_COEF + 2;
    localparam int unsigned PW    = KW + EW;
    // Wide enough for both u1 and the full products, plus carry headroom for the sum.
    localparam int unsigned AW    = ((W_OUT > PW) ? W_OUT : PW) + 3;

    logic signed [W_DATA-1:0] cfg_setpoint;
    logic signed [KW-1:0]     cfg_k1, cfg_k2, cfg_k3;
    logic [N_CHAN-1:0]        clr_rqst;

    logic signed [EW-1:0]     e1_q [N_CHAN];
    logic signed [EW-1:0]     e2_q [N_CHAN];
    logic signed [W_OUT-1:0]  u1_q [N_CHAN];

    // Stage 1 -> 2 registers
    logic                     s1_valid_q;
    logic [W_CHAN-1:0]        s1_chan_q;
    logic signed [EW-1:0]     s1_e_q;
    logic signed [KW-1:0]     s1_k1_q, s1_k2_q, s1_k3_q;
    // Stage 2 -> 3 registers
    logic                     s2_valid_q;
    logic [W_CHAN-1:0]        s2_chan_q;
    logic signed [EW-1:0]     s2_e_q, s2_e1_q;
    logic signed [PW-1:0]     s2_m1_q, s2_m2_q, s2_m3_q;
    // Output registers
    logic                     dv_out_q;
    logic [W_CHAN-1:0]        chan_out_q;
    logic [W_OUT-1:0]         data_out_q;

    logic [W_IDX-1:0]         in_idx, idx2, idx3;
    logic                     in_ok, fwd3, wb;
    logic signed [EW-1:0]     e_in, e1_cur, e2_cur;
    logic signed [PW-1:0]     k1_w, k2_w, k3_w, e_w, e1_w, e2_w, m1, m2, m3;
    logic signed [W_OUT-1:0]  u1_cur, u_sat;
    logic signed [AW-1:0]     acc;
    logic signed [63:0]       acc_ext, sat_full;
    logic                     unused_sat;

    pid_filter_cfg_regs #(
        .N_CHAN    (N_CHAN),
        .W_IDX     (W_IDX),
        .W_DATA    (W_DATA),
        .W_COEF    (W_COEF),
        .W_WR_ADDR (W_WR_ADDR),
        .W_WR_CHAN (W_WR_CHAN),
        .W_WR_DATA (W_WR_DATA)
    ) u_cfg_regs (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_chan     (wr_chan),
        .wr_data     (wr_data),
        .rd_idx      (in_idx),
        .rd_setpoint (cfg_setpoint),
        .rd_k1       (cfg_k1),
        .rd_k2       (cfg_k2),
        .rd_k3       (cfg_k3),
        .clr_rqst    (clr_rqst)
    );

    // Stage 1: config fetch and error.
    assign in_idx = chan_in[W_IDX-1:0];
    assign in_ok  = dv_in && (chan_in < W_CHAN'(N_CHAN));
    assign e_in   = {cfg_setpoint[W_DATA-1], cfg_setpoint} - {data_in[W_DATA-1], data_in};

    // Stage 2: a same-channel sample in stage 3 has not written back yet, so its e is the
    // newest e1 and the stored e1 (its predecessor's e) becomes e2.
    assign idx2   = s1_chan_q[W_IDX-1:0];
    assign fwd3   = s2_valid_q && (s2_chan_q == s1_chan_q);
    assign e1_cur = fwd3 ? s2_e_q : e1_q[idx2];
    assign e2_cur = fwd3 ? e1_q[idx2] : e2_q[idx2];
    assign k1_w   = {{EW{s1_k1_q[KW-1]}}, s1_k1_q};
    assign k2_w   = {{EW{s1_k2_q[KW-1]}}, s1_k2_q};
    assign k3_w   = {{EW{s1_k3_q[KW-1]}}, s1_k3_q};
    assign e_w    = {{KW{s1_e_q[EW-1]}}, s1_e_q};
    assign e1_w   = {{KW{e1_cur[EW-1]}}, e1_cur};
    assign e2_w   = {{KW{e2_cur[EW-1]}}, e2_cur};
    assign m1     = k1_w * e_w;
    assign m2     = k2_w * e1_w;
    assign m3     = k3_w * e2_w;

    // Stage 3: u1 is read here, by which point any older same-channel result is stored.
    assign idx3     = s2_chan_q[W_IDX-1:0];
    assign u1_cur   = u1_q[idx3];
    assign acc      = {{(AW-W_OUT){u1_cur[W_OUT-1]}}, u1_cur}
                    + {{(AW-PW){s2_m1_q[PW-1]}}, s2_m1_q}
                    + {{(AW-PW){s2_m2_q[PW-1]}}, s2_m2_q}
                    + {{(AW-PW){s2_m3_q[PW-1]}}, s2_m3_q};
    assign acc_ext  = {{(64-AW){acc[AW-1]}}, acc};
    assign sat_full = sat_signed(acc_ext, W_OUT);
    assign u_sat    = sat_full[W_OUT-1:0];
    assign unused_sat = ^sat_full[63:W_OUT];
    assign wb       = s2_valid_q && !clr_rqst[idx3];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_valid_q <= 1'b0;
            s1_chan_q  <= '0;
            s1_e_q     <= '0;
            s1_k1_q    <= '0;
            s1_k2_q    <= '0;
            s1_k3_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_chan_q  <= '0;
            s2_e_q     <= '0;
            s2_e1_q    <= '0;
            s2_m1_q    <= '0;
            s2_m2_q    <= '0;
            s2_m3_q    <= '0;
            dv_out_q   <= 1'b0;
            chan_out_q <= '0;
            data_out_q <= '0;
        end else begin
            s1_valid_q <= in_ok && !clr_rqst[in_idx];
            s1_chan_q  <= chan_in;
            s1_e_q     <= e_in;
            s1_k1_q    <= cfg_k1;
            s1_k2_q    <= cfg_k2;
            s1_k3_q    <= cfg_k3;
            s2_valid_q <= s1_valid_q && !clr_rqst[idx2];
            s2_chan_q  <= s1_chan_q;
            s2_e_q     <= s1_e_q;
            s2_e1_q    <= e1_cur;
            s2_m1_q    <= m1;
            s2_m2_q    <= m2;
            s2_m3_q    <= m3;
            dv_out_q   <= wb;
            if (wb) begin
                chan_out_q <= s2_chan_q;
                data_out_q <= u_sat;
            end
        end
    end

    // Clear takes priority over a same-cycle writeback to the same channel.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int unsigned c = 0; c < N_CHAN; c++) begin
                e1_q[c] <= '0;
                e2_q[c] <= '0;
                u1_q[c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < N_CHAN; c++) begin
                if (clr_rqst[c]) begin
                    e1_q[c] <= '0;
                    e2_q[c] <= '0;
                    u1_q[c] <= '0;
                end else if (wb && (idx3 == W_IDX'(c))) begin
                    e1_q[c] <= s2_e_q;
                    e2_q[c] <= s2_e1_q;
                    u1_q[c] <= u_sat;
                end
            end
        end
    end

    assign dv_out   = dv_out_q;
    assign chan_out = chan_out_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_pid_filter.sv
// Directed bench for pid_filter (W_OUT=24) with hand-computed outputs, channels and latencies.
module tb_pid_filter;
    import pid_filter_pkg::*;

    localparam int unsigned W_CHAN = 5;
    localparam int unsigned W_DATA = 18;
    localparam int unsigned W_OUT  = 24;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               dv_in;
    logic [W_CHAN-1:0]  chan_in;
    logic [W_DATA-1:0]  data_in;
    logic               wr_en;
    logic [15:0]        wr_addr;
    logic [15:0]        wr_chan;
    logic [47:0]        wr_data;
    logic               dv_out;
    logic [W_CHAN-1:0]  chan_out;
    logic [W_OUT-1:0]   data_out;

    pid_filter #(
        .W_CHAN (W_CHAN),
        .W_DATA (W_DATA),
        .W_OUT  (W_OUT)
    ) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .dv_in    (dv_in),
        .chan_in  (chan_in),
        .data_in  (data_in),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_chan  (wr_chan),
        .wr_data  (wr_data),
        .dv_out   (dv_out),
        .chan_out (chan_out),
        .data_out (data_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    longint q_cyc[$];
    longint q_chan[$];
    longint q_data[$];
    always @(negedge clk_in) begin
        if (dv_out) begin
            q_cyc.push_back(longint'(cyc));
            q_chan.push_back(longint'(chan_out));
            q_data.push_back(longint'($signed(data_out)));
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic cfg_write(input int unsigned addr, input int ch, input longint val);
        wr_en   = 1'b1;
        wr_addr = 16'(addr);
        wr_chan = 16'(ch);
        wr_data = 48'(val);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic send(input int ch, input int d, output longint t);
        dv_in   = 1'b1;
        chan_in = W_CHAN'(ch);
        data_in = W_DATA'(d);
        t       = longint'(cyc);
        tick();
        dv_in   = 1'b0;
    endtask

    task automatic expect_out(input string tag, input longint t_in, input int ch, input longint d);
        check_eq({tag, "_present"}, longint'(q_data.size() > 0), 1);
        if (q_data.size() > 0) begin
            check_eq({tag, "_chan"}, q_chan.pop_front(), longint'(ch));
            check_eq({tag, "_data"}, q_data.pop_front(), d);
            check_eq({tag, "_latency"}, q_cyc.pop_front() - t_in, 3);
        end
    endtask

    task automatic expect_empty(input string tag);
        check_eq(tag, longint'(q_data.size()), 0);
    endtask

    longint t0, t1, t2, t3;

    initial begin
        rst_in  = 1'b1;
        dv_in   = 1'b0;
        chan_in = '0;
        data_in = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_chan = '0;
        wr_data = '0;
        idle(2);
        check_eq("reset_dv_out", longint'(dv_out), 0);
        check_eq("reset_chan_out", longint'(chan_out), 0);
        check_eq("reset_data_out", longint'(data_out), 0);
        rst_in = 1'b0;
        idle(1);

        // Proportional, back-to-back same channel.
        cfg_write(pid_setpoint_addr, 2, 100);
        cfg_write(pid_p_coef_addr, 2, 1);
        send(2, 40, t0);
        send(2, 40, t1);
        idle(5);
        expect_out("p_0", t0, 2, 60);
        expect_out("p_1", t1, 2, 60);
        expect_empty("p_done");

        // Integral, four consecutive samples.
        cfg_write(pid_setpoint_addr, 1, 10);
        cfg_write(pid_i_coef_addr, 1, 1);
        send(1, 0, t0);
        send(1, 0, t1);
        send(1, 0, t2);
        send(1, 0, t3);
        idle(5);
        expect_out("i_0", t0, 1, 10);
        expect_out("i_1", t1, 1, 20);
        expect_out("i_2", t2, 1, 30);
        expect_out("i_3", t3, 1, 40);
        expect_empty("i_done");

        // Derivative, back-to-back then interleaved with chan 3 after a clear.
        cfg_write(pid_d_coef_addr, 0, 1);
        send(0, -5, t0);
        send(0, -5, t1);
        idle(5);
        expect_out("d_0", t0, 0, 5);
        expect_out("d_1", t1, 0, 0);
        cfg_write(pid_clr_rqst_addr, 0, 1);
        idle(2);
        send(0, -5, t0);
        send(3, 7, t1);
        send(0, -5, t2);
        idle(5);
        expect_out("dx_0", t0, 0, 5);
        expect_out("dx_3", t1, 3, 0);
        expect_out("dx_1", t2, 0, 0);
        expect_empty("d_done");

        // Saturation at both rails.
        cfg_write(pid_setpoint_addr, 4, 131071);
        cfg_write(pid_i_coef_addr, 4, 32767);
        send(4, -131072, t0);
        send(4, -131072, t1);
        idle(5);
        expect_out("sat_hi_0", t0, 4, 8388607);
        expect_out("sat_hi_1", t1, 4, 8388607);
        cfg_write(pid_setpoint_addr, 4, -131072);
        send(4, 131071, t0);
        send(4, 131071, t1);
        idle(5);
        expect_out("sat_lo_0", t0, 4, -8388608);
        expect_out("sat_lo_1", t1, 4, -8388608);
        expect_empty("sat_done");

        // Clear chan 1 with two chan 1 samples in flight, chan 0 around them.
        send(0, 0, t0);
        send(1, 0, t1);
        wr_en   = 1'b1;
        wr_addr = 16'(pid_clr_rqst_addr);
        wr_chan = 16'd1;
        wr_data = 48'd1;
        send(1, 0, t2);
        wr_en   = 1'b0;
        send(0, -3, t3);
        idle(5);
        expect_out("clr_ch0_a", t0, 0, -5);
        expect_out("clr_ch0_b", t3, 0, 3);
        expect_empty("clr_dropped");
        send(1, 0, t0);
        idle(5);
        expect_out("clr_restart", t0, 1, 10);
        expect_empty("clr_done");

        // Reset mid-stream.
        send(2, 40, t0);
        send(2, 40, t1);
        rst_in = 1'b1;
        #1;
        check_eq("rst_dv_out", longint'(dv_out), 0);
        check_eq("rst_chan_out", longint'(chan_out), 0);
        check_eq("rst_data_out", longint'(data_out), 0);
        idle(2);
        rst_in = 1'b0;
        idle(4);
        expect_empty("rst_drop");
        send(2, 40, t0);
        idle(5);
        expect_out("rst_after", t0, 2, 0);
        expect_empty("rst_done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pid_filter.md
# pid_filter

Per-channel discrete PID stage that sits directly downstream of the oversample filter. It consumes the filter's averaged `dv/chan/data` stream and computes a velocity-form PID update per channel against a per-channel setpoint. It emits a saturated signed controller output tagged with the same channel, which goes to the output router. Setpoint, gains and per-channel clears are programmed over the shared `wr_*` configuration bus.

## Interface
Parameters:
- `W_CHAN`, 5: channel tag width
- `N_CHAN`, 8: number of channels
- `W_DATA`, 18: signed input sample width
- `W_COEF`, 16: signed P/I/D gain width
- `W_OUT`, 48: signed output width
- `W_WR_ADDR`, 16: config address width
- `W_WR_CHAN`, 16: config channel width
- `W_WR_DATA`, 48: config data width

Ports:
- `clk_in`  in  1  single clock; all logic is in this domain
- `rst_in`  in  1  asynchronous, active-high reset
- `dv_in`  in  1  input sample valid, one cycle per sample
- `chan_in`  in  W_CHAN  input channel tag
- `data_in`  in  W_DATA  signed input sample
- `wr_en`  in  1  config write strobe
- `wr_addr`  in  W_WR_ADDR  config address, decoded against the shared endpoint map
- `wr_chan`  in  W_WR_CHAN  target channel
- `wr_data`  in  W_WR_DATA  write value
- `dv_out`  out  1  output valid
- `chan_out`  out  W_CHAN  output channel tag
- `data_out`  out  W_OUT  signed controller output

## Operation
Configuration:
- Each channel has four config registers, all resetting to 0: `setpoint` (W_DATA), `p`, `i`, `d` (each W_COEF). Writes take `wr_data` LSBs.
- On every gain write, derived gains are recomputed and registered at W_COEF+2 bits:
  - `k1 = p+i+d`
  - `k2 = -p-2d`
  - `k3 = d`
- `pid_clr_rqst_addr` with `wr_data[0]=1` sets `clr_rqst[chan]`. The bit is high for exactly one cycle, then self-clears.

Datapath, per-channel state `e1`, `e2` (W_DATA+1) and `u1` (W_OUT), all reset to 0:
- `e = setpoint - data_in`, computed at W_DATA+1 bits, no saturation needed.
- `u = u1 + k1*e + k2*e1 + k3*e2`, accumulated at W_OUT+3 bits, then saturated to [-(2^(W_OUT-1)), 2^(W_OUT-1)-1].
- Writeback: `e2 <= e1`, `e1 <= e`, `u1 <=` saturated `u`.

Hazards:
- Consecutive samples of the same channel, including back-to-back cycles, must see the state produced by the preceding sample. Forward state from stage 2 and stage 3; no bubbles and no stalls.
- Samples with `dv_in=0` never modify state.

Clear and reset:
- While `clr_rqst[c]` or `rst_in` is high, `e1`, `e2`, `u1` of channel c are zeroed. Any in-flight sample of c has its dv dropped in every stage.
- Clear wins over a same-cycle writeback. Forwarding must not resurrect cleared state.

## Timing
- Three-stage pipeline:
  - Stage 1: fetch config and state, compute `e`.
  - Stage 2: three multiplies.
  - Stage 3: sum, saturate, writeback.
- Latency is 3 cycles from `dv_in` to `dv_out`. Throughput is 1 sample/cycle.
- Config writes are registered. A sample accepted in the cycle after the write uses the new value. A sample already past stage 1 uses the old value.
- Reset values: `dv_out=0`, `chan_out=0`, `data_out=0`. All pipeline valids and all state and config are 0.
- Reset asserted mid-stream drops every in-flight sample asynchronously. The first output after deassertion is for a sample accepted after deassertion.

## Structure
- Endpoint addresses (`pid_setpoint_addr`, `pid_p_coef_addr`, `pid_i_coef_addr`, `pid_d_coef_addr`, `pid_clr_rqst_addr`) belong in the shared endpoint-map include.
- Saturation helpers belong in the shared functions include.
- One sub-module is natural: `pid_cfg_regs`, which holds per-channel config, derived gains and clear requests.

## Test plan
- P=1, setpoint=100, chan 2, data_in=40 twice -> `data_out` 60, 60 on chan 2, each 3 cycles after its input.
- I=1, setpoint=10, data_in=0 on 4 consecutive cycles, chan 1 -> outputs 10, 20, 30, 40 on cycles t+3..t+6 (exercises forwarding).
- D=1, setpoint=0, data_in=-5 then -5 -> outputs 5 then 0. Interleaving chan 3 samples between them does not change chan 0 results.
- W_OUT=24, I=32767, setpoint=131071, data_in=-131072 -> output 8388607 on every sample. Negated setpoint/data -> -8388608.
- Clear chan 1 while two chan 1 samples are in flight -> neither emits `dv_out`. The next sample restarts from zero state. Chan 0 samples in flight are unaffected.
- `rst_in` pulse mid-stream -> outputs 0 immediately, no `dv_out` for pre-reset samples. Config reads back as 0, so the next output is 0.
